// File: rtl/sram_pin_arbiter.sv
// Two-port round-robin arbiter that sequences read/write requests onto the
// nibble-serial SRAM pin bus; each SRAM beat is an L (clk low) and H (clk high) cycle.
`timescale 1ns/1ps

module sram_pin_arbiter #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 8,
    parameter int unsigned NW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          sram_clk,
    output logic          sram_we,
    output logic          sram_oe,
    output logic          sram_commit,
    output logic [NW-1:0] sram_nib,
    input  logic [DW-1:0] sram_dout
);

    typedef enum logic [3:0] {
        IDLE, W_LO_L, W_LO_H, W_HI_L, W_HI_H, W_CM_L, W_CM_H, R_L, R_H, R_CAP
    } state_t;

    state_t        state;
    logic          last_grant;
    logic          cur_id;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;

    logic          idle_c;
    logic          grant0_c;
    logic          grant1_c;
    logic          sel_we_c;
    logic [AW-1:0] sel_addr_c;
    logic [DW-1:0] sel_wdata_c;

    // Grant decision: a lone requester wins, contention goes to the port not served last.
    always_comb begin
        idle_c      = (state == IDLE) && !reset;
        grant0_c    = idle_c && req0_valid && (!req1_valid || last_grant);
        grant1_c    = idle_c && req1_valid && (!req0_valid || !last_grant);
        sel_we_c    = grant1_c ? req1_we    : req0_we;
        sel_addr_c  = grant1_c ? req1_addr  : req0_addr;
        sel_wdata_c = grant1_c ? req1_wdata : req0_wdata;
    end

    assign req0_ready = grant0_c;
    assign req1_ready = grant1_c;

    // Sequencer: strobes and nibble change only on entry to L states; H states only raise sram_clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            cur_id      <= 1'b0;
            cur_addr    <= '0;
            cur_wdata   <= '0;
            sram_clk    <= 1'b0;
            sram_we     <= 1'b0;
            sram_oe     <= 1'b0;
            sram_commit <= 1'b0;
            sram_nib    <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_rdata  <= '0;
            rsp1_rdata  <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0_c || grant1_c) begin
                        cur_id     <= grant1_c;
                        last_grant <= grant1_c;
                        cur_addr   <= sel_addr_c;
                        cur_wdata  <= sel_wdata_c;
                        if (sel_we_c) begin
                            state    <= W_LO_L;
                            sram_we  <= 1'b1;
                            sram_nib <= sel_wdata_c[NW-1:0];
                        end else begin
                            state    <= R_L;
                            sram_oe  <= 1'b1;
                            sram_nib <= NW'(sel_addr_c);
                        end
                    end
                end
                W_LO_L: begin
                    state    <= W_LO_H;
                    sram_clk <= 1'b1;
                end
                W_LO_H: begin
                    state    <= W_HI_L;
                    sram_clk <= 1'b0;
                    sram_nib <= cur_wdata[DW-1:NW];
                end
                W_HI_L: begin
                    state    <= W_HI_H;
                    sram_clk <= 1'b1;
                end
                W_HI_H: begin
                    state       <= W_CM_L;
                    sram_clk    <= 1'b0;
                    sram_we     <= 1'b0;
                    sram_commit <= 1'b1;
                    sram_nib    <= NW'(cur_addr);
                end
                W_CM_L: begin
                    state    <= W_CM_H;
                    sram_clk <= 1'b1;
                end
                W_CM_H: begin
                    state       <= IDLE;
                    sram_clk    <= 1'b0;
                    sram_commit <= 1'b0;
                    sram_nib    <= '0;
                    if (cur_id) rsp1_valid <= 1'b1;
                    else        rsp0_valid <= 1'b1;
                end
                R_L: begin
                    state    <= R_H;
                    sram_clk <= 1'b1;
                end
                R_H: begin
                    state    <= R_CAP;
                    sram_clk <= 1'b0;
                end
                R_CAP: begin
                    state    <= IDLE;
                    sram_oe  <= 1'b0;
                    sram_nib <= '0;
                    if (cur_id) begin
                        rsp1_valid <= 1'b1;
                        rsp1_rdata <= sram_dout;
                    end else begin
                        rsp0_valid <= 1'b1;
                        rsp0_rdata <= sram_dout;
                    end
                end
                default: begin
                    state       <= IDLE;
                    sram_clk    <= 1'b0;
                    sram_we     <= 1'b0;
                    sram_oe     <= 1'b0;
                    sram_commit <= 1'b0;
                    sram_nib    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_pin_arbiter.sv
// Directed bench for sram_pin_arbiter with a behavioural nibble-serial SRAM
// on the pins, pin-protocol monitor and a random single-request soak.
`timescale 1ns/1ps

module tb_sram_pin_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req0_we, rsp0_valid;
    logic [2:0] req0_addr;
    logic [7:0] req0_wdata, rsp0_rdata;
    logic       req1_valid, req1_ready, req1_we, rsp1_valid;
    logic [2:0] req1_addr;
    logic [7:0] req1_wdata, rsp1_rdata;
    logic       sram_clk, sram_we, sram_oe, sram_commit;
    logic [3:0] sram_nib;
    logic [7:0] sram_dout;

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    sram_pin_arbiter #(.AW(3), .DW(8), .NW(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .sram_clk(sram_clk), .sram_we(sram_we), .sram_oe(sram_oe),
        .sram_commit(sram_commit), .sram_nib(sram_nib), .sram_dout(sram_dout)
    );

    // Behavioural SRAM: nibbles shift in low-first on we, commit stores at the nibble address.
    logic [7:0] mem [8];
    logic [7:0] shreg = 8'h00;
    logic [2:0] raddr = 3'd0;
    always @(posedge sram_clk) begin
        if (sram_we)     shreg <= {sram_nib, shreg[7:4]};
        if (sram_commit) mem[sram_nib[2:0]] <= shreg;
        if (sram_oe)     raddr <= sram_nib[2:0];
    end
    assign sram_dout = sram_oe ? mem[raddr] : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] pins();
        return {sram_clk, sram_we, sram_oe, sram_commit, sram_nib, rsp0_valid, rsp1_valid};
    endfunction

    // Pin-protocol invariants, sampled every cycle on the falling edge.
    logic [7:0] prev = 8'h00;
    bit         prev_ok = 1'b0;
    always @(negedge clk) begin
        if (reset || !mon_en) begin
            prev_ok <= 1'b0;
        end else begin
            check("inv_we_oe", 32'(sram_we & sram_oe), 32'd0);
            check("inv_onehot", 32'($countones({sram_we, sram_oe, sram_commit}) <= 1), 32'd1);
            if (sram_oe || sram_commit) check("inv_addr_nib", 32'(sram_nib[3]), 32'd0);
            if (prev_ok && !prev[7] && sram_clk)
                check("inv_rise_hold", 32'({sram_we, sram_oe, sram_commit, sram_nib}), 32'(prev[6:0]));
            prev_ok <= 1'b1;
        end
        prev <= {sram_clk, sram_we, sram_oe, sram_commit, sram_nib};
    end

    task automatic xact(input bit p, input logic w, input logic [2:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int lat);
        @(posedge clk); #1;
        if (!p) begin req0_valid = 1'b1; req0_we = w; req0_addr = a; req0_wdata = d; end
        else    begin req1_valid = 1'b1; req1_we = w; req1_addr = a; req1_wdata = d; end
        @(negedge clk);
        check("xact_ready", 32'(p ? req1_ready : req0_ready), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 0;
        rd  = 8'h00;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (p ? rsp1_valid : rsp0_valid) begin
                lat = k;
                rd  = p ? rsp1_rdata : rsp0_rdata;
                break;
            end
        end
    endtask

    logic [9:0] t1 [7];
    logic [9:0] t2 [4];
    logic [7:0] ref_mem [8];
    logic [7:0] rd;
    int         lat;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  g, i0, n1, r0c, r1c;
        bit  g0, g1, sp, sw;
        logic [2:0] sa;
        logic [7:0] sd;

        t1 = '{{4'b0100, 4'h7, 2'b00}, {4'b1100, 4'h7, 2'b00}, {4'b0100, 4'hA, 2'b00},
               {4'b1100, 4'hA, 2'b00}, {4'b0001, 4'h5, 2'b00}, {4'b1001, 4'h5, 2'b00},
               {4'b0000, 4'h0, 2'b10}};
        t2 = '{{4'b0010, 4'h5, 2'b00}, {4'b1010, 4'h5, 2'b00}, {4'b0010, 4'h5, 2'b00},
               {4'b0000, 4'h0, 2'b01}};

        // Reset with a pending request: nothing may be granted or driven.
        reset = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 3'd5; req0_wdata = 8'hA7;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 3'd0; req1_wdata = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pins", 32'(pins()), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst_rdata", 32'({rsp0_rdata, rsp1_rdata}), 32'd0);
        mon_en = 1'b1;

        // Port 0 write addr 5 data A7.
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("wr_ready", 32'({req0_ready, req1_ready}), 32'b10);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            if (c == 1) req0_valid = 1'b0;
            @(negedge clk);
            check($sformatf("wr_pins_c%0d", c), 32'(pins()), 32'(t1[c-1]));
        end
        check("wr_mem5", 32'(mem[5]), 32'hA7);

        // Port 1 read addr 5.
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 3'd5;
        @(negedge clk);
        check("rd_ready", 32'({req0_ready, req1_ready}), 32'b01);
        check("rsp0_one_cycle", 32'(rsp0_valid), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) req1_valid = 1'b0;
            @(negedge clk);
            check($sformatf("rd_pins_c%0d", c), 32'(pins()), 32'(t2[c-1]));
        end
        check("rd_rdata1", 32'(rsp1_rdata), 32'hA7);
        check("rd_rdata0_held", 32'(rsp0_rdata), 32'h00);

        // Contention: p0 writes addr i data 10+i, p1 reads addr 0; grants must alternate.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 3'd0; req0_wdata = 8'h10;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 3'd0;
        g = 0; i0 = 0; n1 = 0; r0c = 0; r1c = 0;
        for (int cyc = 0; cyc < 400 && (g < 16 || r0c < 8 || r1c < 8); cyc++) begin
            @(negedge clk);
            if (rsp0_valid) r0c++;
            if (rsp1_valid) begin
                r1c++;
                check("arb_rdata", 32'(rsp1_rdata), 32'h10);
            end
            g0 = req0_ready;
            g1 = req1_ready;
            if (g0 || g1) begin
                check($sformatf("arb_grant_%0d", g), 32'({g0, g1}), (g % 2 == 0) ? 32'b10 : 32'b01);
                g++;
            end
            @(posedge clk); #1;
            if (g0) begin
                i0++;
                if (i0 == 8) req0_valid = 1'b0;
                else begin req0_addr = 3'(i0); req0_wdata = 8'(8'h10 + i0); end
            end
            if (g1) begin
                n1++;
                if (n1 == 8) req1_valid = 1'b0;
            end
        end
        check("arb_grants", 32'(g), 32'd16);
        check("arb_rsp0", 32'(r0c), 32'd8);
        check("arb_rsp1", 32'(r1c), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("arb_mem%0d", i), 32'(mem[i]), 32'(8'h10 + i));

        // Back-to-back reads on port 0: addr 2 then 3.
        xact(1'b0, 1'b1, 3'd2, 8'h22, rd, lat);
        check("pre2_lat", 32'(lat), 32'd7);
        xact(1'b0, 1'b1, 3'd3, 8'h33, rd, lat);
        check("pre3_lat", 32'(lat), 32'd7);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 3'd2;
        @(negedge clk);
        check("b2b_ready0", 32'(req0_ready), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) req0_addr = 3'd3;
            if (c == 5) req0_valid = 1'b0;
            @(negedge clk);
            check($sformatf("b2b_ready_c%0d", c), 32'(req0_ready), (c == 4) ? 32'd1 : 32'd0);
            check($sformatf("b2b_rsp_c%0d", c), 32'(rsp0_valid), (c == 4 || c == 8) ? 32'd1 : 32'd0);
            if (c == 4 || c == 6) check($sformatf("b2b_rdata_c%0d", c), 32'(rsp0_rdata), 32'h22);
            if (c == 8) check("b2b_rdata_c8", 32'(rsp0_rdata), 32'h33);
        end

        // Write addr 4 data 5C aborted by reset in W_HI_H; memory keeps 14.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 3'd4; req0_wdata = 8'h5C;
        @(negedge clk);
        check("abort_ready", 32'(req0_ready), 32'd1);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) req0_valid = 1'b0;
            if (c == 4) reset = 1'b1;
            @(negedge clk);
        end
        check("abort_w_hi_h", 32'(pins()), 32'({4'b1100, 4'h5, 2'b00}));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_pins", 32'(pins()), 32'd0);
        check("abort_rdata_rst", 32'(rsp0_rdata), 32'h00);
        r0c = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp0_valid) r0c++;
        end
        check("abort_no_rsp", 32'(r0c), 32'd0);
        xact(1'b0, 1'b0, 3'd4, 8'h00, rd, lat);
        check("abort_rd_lat", 32'(lat), 32'd4);
        check("abort_rd_data", 32'(rd), 32'h14);

        // Random soak, one request at a time, against a reference memory.
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'(8'h10 + i);
        ref_mem[2] = 8'h22;
        ref_mem[3] = 8'h33;
        for (int n = 0; n < 2000; n++) begin
            sp = 1'($urandom_range(0, 1));
            sw = 1'($urandom_range(0, 1));
            sa = 3'($urandom_range(0, 7));
            sd = 8'($urandom_range(0, 255));
            xact(sp, sw, sa, sd, rd, lat);
            check("soak_lat", 32'(lat), sw ? 32'd7 : 32'd4);
            if (sw) ref_mem[sa] = sd;
            else    check("soak_rdata", 32'(rd), 32'(ref_mem[sa]));
        end
        for (int i = 0; i < 8; i++)
            check($sformatf("soak_mem%0d", i), 32'(mem[i]), 32'(ref_mem[i]));

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
